// File: rtl/decode_stage.sv
// decode_stage: registered MIPS-subset decode stage with valid/ready handshake, stall and flush.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_opcode,
    output logic [5:0]      out_funct,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_shamt,
    output logic [4:0]      out_dest,
    output logic            out_reg_write,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [2:0]      out_class,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);
    typedef struct packed {
        logic [5:0]      opcode;
        logic [5:0]      funct;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      shamt;
        logic [4:0]      dest;
        logic            reg_write;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      cls;
        logic [XLEN-1:0] pc;
    } payload_t;

    payload_t        dec, pl_d, pl_q;
    logic            valid_d, valid_q, in_xfer, out_xfer, fn_ok;
    logic [5:0]      op, fn;
    logic [XLEN-1:0] sext, zext, pc4;

    assign op       = in_instr[31:26];
    assign fn       = in_instr[5:0];
    assign fn_ok    = fn inside {6'h00, 6'h02, 6'h03, 6'h08, [6'h20:6'h27], 6'h2A, 6'h2B};
    assign sext     = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
    assign zext     = {{(XLEN-16){1'b0}}, in_instr[15:0]};
    assign pc4      = in_pc + XLEN'(4);
    assign in_ready = !valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = valid_q && out_ready;

    always_comb begin
        dec           = '0;
        dec.opcode    = op;
        dec.funct     = fn;
        dec.rs        = in_instr[25:21];
        dec.rt        = in_instr[20:16];
        dec.shamt     = in_instr[10:6];
        dec.pc        = in_pc;
        dec.cls       = op == 6'h00 ? (fn_ok ? (fn == 6'h08 ? 3'd5 : 3'd0) : 3'd7) :
                        (op == 6'h02 || op == 6'h03) ? 3'd5 :
                        (op == 6'h04 || op == 6'h05) ? 3'd4 :
                        op[5:3] == 3'b001 ? 3'd1 :
                        op == 6'h23 ? 3'd2 :
                        op == 6'h2B ? 3'd3 : 3'd7;
        // LUI: sext already replicates bit 15 upward, so shifting it left yields sign extension from bit 31
        dec.imm       = dec.cls == 3'd7 ? '0 :
                        op inside {6'h0C, 6'h0D, 6'h0E} ? zext :
                        op == 6'h0F ? sext << 16 : sext;
        dec.target    = dec.cls == 3'd4 ? pc4 + (sext << 2) :
                        (op == 6'h02 || op == 6'h03) ? {pc4[XLEN-1:28], in_instr[25:0], 2'b00} : '0;
        dec.dest      = dec.cls == 3'd0 ? in_instr[15:11] :
                        (dec.cls == 3'd1 || dec.cls == 3'd2) ? in_instr[20:16] :
                        op == 6'h03 ? 5'd31 : 5'd0;
        dec.reg_write = dec.dest != 5'd0;
        valid_d       = flush ? 1'b0 : in_xfer ? 1'b1 : out_xfer ? 1'b0 : valid_q;
        pl_d          = (in_xfer && !flush) ? dec : pl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pl_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pl_q    <= pl_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_opcode    = pl_q.opcode;
    assign out_funct     = pl_q.funct;
    assign out_rs        = pl_q.rs;
    assign out_rt        = pl_q.rt;
    assign out_shamt     = pl_q.shamt;
    assign out_dest      = pl_q.dest;
    assign out_reg_write = pl_q.reg_write;
    assign out_imm       = pl_q.imm;
    assign out_target    = pl_q.target;
    assign out_class     = pl_q.cls;
    assign out_illegal   = &pl_q.cls;
    assign out_pc        = pl_q.pc;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage (32-bit and 64-bit instances).
module tb_decode_stage;
    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic        in_ready, out_valid, out_reg_write, out_illegal;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  out_rs, out_rt, out_shamt, out_dest;
    logic [31:0] out_imm, out_target, out_pc;
    logic [2:0]  out_class;

    logic        v64_in_valid = 0, v64_in_ready, v64_out_valid, v64_reg_write, v64_illegal;
    logic [31:0] v64_instr = '0;
    logic [63:0] v64_pc = '0, v64_imm, v64_target, v64_out_pc;
    logic [5:0]  v64_opcode, v64_funct;
    logic [4:0]  v64_rs, v64_rt, v64_shamt, v64_dest;
    logic [2:0]  v64_class;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_funct(out_funct), .out_rs(out_rs), .out_rt(out_rt),
        .out_shamt(out_shamt), .out_dest(out_dest), .out_reg_write(out_reg_write),
        .out_imm(out_imm), .out_target(out_target), .out_class(out_class),
        .out_illegal(out_illegal), .out_pc(out_pc)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(v64_in_valid), .in_ready(v64_in_ready),
        .in_instr(v64_instr), .in_pc(v64_pc), .out_valid(v64_out_valid), .out_ready(1'b1),
        .out_opcode(v64_opcode), .out_funct(v64_funct), .out_rs(v64_rs), .out_rt(v64_rt),
        .out_shamt(v64_shamt), .out_dest(v64_dest), .out_reg_write(v64_reg_write),
        .out_imm(v64_imm), .out_target(v64_target), .out_class(v64_class),
        .out_illegal(v64_illegal), .out_pc(v64_out_pc)
    );

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1; in_instr = instr; in_pc = pc;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic test_reset;
        rst_n = 0; in_valid = 1; in_instr = 32'h2009FFFF; in_pc = 32'h80;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if ({out_imm, out_target, out_pc} !== '0) begin failures++; $display("FAIL rst_payload got=%h %h %h exp=0", out_imm, out_target, out_pc); end
        checks++; if ({out_class, out_dest, out_reg_write, out_illegal, out_opcode, out_funct, out_rs, out_rt, out_shamt} !== '0) begin failures++; $display("FAIL rst_fields got nonzero class=%0d dest=%0d", out_class, out_dest); end
        rst_n = 1;
        @(posedge clk); #1;
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
        checks++; if (out_class !== 3'd1) begin failures++; $display("FAIL addi_class got=%0d exp=1", out_class); end
        checks++; if (out_imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL addi_imm got=%h exp=ffffffff", out_imm); end
        checks++; if (out_dest !== 5'd9 || out_reg_write !== 1'b1) begin failures++; $display("FAIL addi_dest got=%0d/%b exp=9/1", out_dest, out_reg_write); end
        checks++; if (out_pc !== 32'h80) begin failures++; $display("FAIL addi_pc got=%h exp=80", out_pc); end
    endtask

    task automatic test_immediates;
        send(32'h3409FFFF, 32'h0);
        checks++; if (out_imm !== 32'h0000FFFF) begin failures++; $display("FAIL ori_imm got=%h exp=0000ffff", out_imm); end
        send(32'h3C011234, 32'h0);
        checks++; if (out_imm !== 32'h12340000 || out_dest !== 5'd1) begin failures++; $display("FAIL lui_imm got=%h/%0d exp=12340000/1", out_imm, out_dest); end
        send(32'h8C22FFF0, 32'h0);
        checks++; if (out_class !== 3'd2 || out_imm !== 32'hFFFFFFF0 || out_dest !== 5'd2 || out_reg_write !== 1'b1) begin failures++; $display("FAIL lw got class=%0d imm=%h dest=%0d", out_class, out_imm, out_dest); end
        send(32'hAC220004, 32'h0);
        checks++; if (out_class !== 3'd3 || out_imm !== 32'h4 || out_dest !== 5'd0 || out_reg_write !== 1'b0) begin failures++; $display("FAIL sw got class=%0d imm=%h dest=%0d", out_class, out_imm, out_dest); end
    endtask

    task automatic test_xlen64;
        v64_in_valid = 1; v64_instr = 32'h3C018000; v64_pc = 64'h1000;
        @(posedge clk); #1;
        v64_in_valid = 0;
        checks++; if (v64_imm !== 64'hFFFFFFFF80000000 || v64_out_valid !== 1'b1) begin failures++; $display("FAIL lui64_imm got=%h exp=ffffffff80000000", v64_imm); end
        checks++; if (v64_class !== 3'd1 || v64_dest !== 5'd1) begin failures++; $display("FAIL lui64_class got=%0d/%0d exp=1/1", v64_class, v64_dest); end
    endtask

    task automatic test_targets;
        send(32'h1000FFFF, 32'h100);
        checks++; if (out_class !== 3'd4 || out_target !== 32'h100) begin failures++; $display("FAIL beq got class=%0d target=%h exp=4/100", out_class, out_target); end
        checks++; if (out_reg_write !== 1'b0 || out_dest !== 5'd0) begin failures++; $display("FAIL beq_dest got=%0d/%b exp=0/0", out_dest, out_reg_write); end
        send(32'h0C000010, 32'h40000000);
        checks++; if (out_class !== 3'd5 || out_target !== 32'h40000040) begin failures++; $display("FAIL jal_target got=%h exp=40000040", out_target); end
        checks++; if (out_dest !== 5'd31 || out_reg_write !== 1'b1) begin failures++; $display("FAIL jal_dest got=%0d/%b exp=31/1", out_dest, out_reg_write); end
        send(32'h08000001, 32'hFFFFFFFC);
        checks++; if (out_target !== 32'h00000004 || out_class !== 3'd5 || out_reg_write !== 1'b0) begin failures++; $display("FAIL j_wrap got=%h exp=00000004", out_target); end
        send(32'h03E00008, 32'h200);
        checks++; if (out_class !== 3'd5 || out_target !== 32'h0 || out_rs !== 5'd31 || out_reg_write !== 1'b0) begin failures++; $display("FAIL jr got class=%0d target=%h rs=%0d", out_class, out_target, out_rs); end
    endtask

    task automatic test_illegal;
        send(32'hFC00FFFF, 32'h0);
        checks++; if (out_class !== 3'd7 || out_illegal !== 1'b1 || out_imm !== 32'h0 || out_reg_write !== 1'b0) begin failures++; $display("FAIL ill_op got class=%0d ill=%b imm=%h", out_class, out_illegal, out_imm); end
        checks++; if (out_opcode !== 6'h3F || out_funct !== 6'h3F) begin failures++; $display("FAIL ill_fields got=%h/%h exp=3f/3f", out_opcode, out_funct); end
        send(32'h00221801, 32'h0);
        checks++; if (out_class !== 3'd7 || out_illegal !== 1'b1 || out_imm !== 32'h0 || out_reg_write !== 1'b0 || out_dest !== 5'd0) begin failures++; $display("FAIL ill_funct got class=%0d imm=%h dest=%0d", out_class, out_imm, out_dest); end
        send(32'h00000020, 32'h0);
        checks++; if (out_class !== 3'd0 || out_illegal !== 1'b0 || out_reg_write !== 1'b0) begin failures++; $display("FAIL rd0 got class=%0d wr=%b exp=0/0", out_class, out_reg_write); end
        send(32'h002218C2, 32'h0);
        checks++; if (out_class !== 3'd0 || out_dest !== 5'd3 || out_reg_write !== 1'b1 || out_shamt !== 5'd3 || out_rt !== 5'd2) begin failures++; $display("FAIL srl got class=%0d dest=%0d shamt=%0d", out_class, out_dest, out_shamt); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vec [3] = '{32'h00221820, 32'h8C22FFF0, 32'h3409FFFF};
        logic [2:0]  cls [3] = '{3'd0, 3'd2, 3'd1};
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; in_instr = vec[k]; in_pc = 32'h600 + 32'(k * 4);
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_class !== cls[k] || out_pc !== 32'h600 + 32'(k * 4)) begin failures++; $display("FAIL b2b_%0d got v=%b class=%0d pc=%h", k, out_valid, out_class, out_pc); end
        end
        in_valid = 0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure;
        logic        pat    [8] = '{1, 0, 0, 1, 1, 1, 1, 1};
        logic        exp_ir [8] = '{1, 0, 0, 1, 1, 1, 1, 1};
        logic        exp_ov [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        logic [31:0] exp_pc [8] = '{0, 32'h10, 32'h10, 32'h10, 32'h14, 32'h18, 32'h1C, 0};
        int sent = 0;
        for (int c = 0; c < 8; c++) begin
            out_ready = pat[c];
            in_valid  = sent < 4;
            in_instr  = 32'h20090000 | 32'(sent);
            in_pc     = 32'h10 + 32'(sent * 4);
            #1;
            checks++; if (in_ready !== exp_ir[c] || out_valid !== exp_ov[c]) begin failures++; $display("FAIL bp_hs_%0d got ir=%b ov=%b exp ir=%b ov=%b", c, in_ready, out_valid, exp_ir[c], exp_ov[c]); end
            if (exp_ov[c]) begin
                checks++; if (out_pc !== exp_pc[c] || out_imm !== (exp_pc[c] - 32'h10) >> 2) begin failures++; $display("FAIL bp_data_%0d got pc=%h imm=%h exp pc=%h", c, out_pc, out_imm, exp_pc[c]); end
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        checks++; if (sent !== 4) begin failures++; $display("FAIL bp_sent got=%0d exp=4", sent); end
    endtask

    task automatic test_flush;
        out_ready = 0;
        send(32'h2009FFFF, 32'h200);
        flush = 1; in_valid = 1; in_instr = 32'h3C011234; in_pc = 32'h300;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_stall_ir got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h200) begin failures++; $display("FAIL flush1 got v=%b pc=%h exp 0/200", out_valid, out_pc); end
        out_ready = 1; in_pc = 32'h304;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ir got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h200) begin failures++; $display("FAIL flush2 got v=%b pc=%h exp 0/200", out_valid, out_pc); end
        send(32'h3409FFFF, 32'h400);
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'h0000FFFF || out_pc !== 32'h400) begin failures++; $display("FAIL post_flush got v=%b imm=%h pc=%h", out_valid, out_imm, out_pc); end
    endtask

    task automatic test_async_reset;
        out_ready = 0;
        send(32'h2009FFFF, 32'h500);
        #2;
        rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL async_rst got v=%b ir=%b exp 0/1", out_valid, in_ready); end
        checks++; if (out_pc !== 32'h0 || out_imm !== 32'h0 || out_dest !== 5'd0) begin failures++; $display("FAIL async_rst_payload got pc=%h imm=%h", out_pc, out_imm); end
        @(negedge clk);
        rst_n = 1; out_ready = 1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_rst_after got=%b exp=0", out_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_immediates();
        test_xlen64();
        test_targets();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage for the MIPS-subset CPU. It accepts a 32-bit instruction and its PC over a valid/ready handshake and splits it into fields. It also classifies the instruction, extends its immediate to XLEN, computes branch/jump targets, selects the destination register and flags illegal encodings. Results are presented one cycle later on a valid/ready output. It sits between instruction fetch and register read/execute and supports stall (backpressure) and flush.

## Interface
- XLEN, 32: datapath width for PC, immediate and target; legal values are ≥ 32.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard the held output and any same-cycle input.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  stage can accept input.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  address of in_instr.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  consumer accepts result.
- out_opcode  out  6  instr[31:26].
- out_funct  out  6  instr[5:0].
- out_rs, out_rt  out  5 each  instr[25:21], instr[20:16].
- out_shamt  out  5  instr[10:6].
- out_dest  out  5  destination register number.
- out_reg_write  out  1  instruction writes out_dest.
- out_imm  out  XLEN  extended immediate.
- out_target  out  XLEN  branch/jump target.
- out_class  out  3  0 R-ALU, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 7 ILLEGAL.
- out_illegal  out  1  opcode/funct not supported (equals class==7).
- out_pc  out  XLEN  registered in_pc.

## Operation
- Supported opcodes:
  - 0x00 R-type.
  - 0x02 J, 0x03 JAL.
  - 0x04 BEQ, 0x05 BNE.
  - 0x08–0x0F: ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI.
  - 0x23 LW, 0x2B SW.
  - Anything else is ILLEGAL.
- Supported R-type functs: 0x00, 0x02, 0x03, 0x08 (JR), 0x20–0x27, 0x2A, 0x2B. Other functs are ILLEGAL.
- Class mapping:
  - R-type → 0, except JR → 5.
  - 0x08–0x0F → 1.
  - LW → 2, SW → 3.
  - BEQ/BNE → 4.
  - J/JAL → 5.
- Immediate (imm = instr[15:0]):
  - Zero-extended for ANDI/ORI/XORI.
  - LUI: {imm,16'b0} sign-extended from bit 31.
  - All other classes: imm sign-extended.
  - ILLEGAL: 0.
- Targets, with pc4 = in_pc + 4 (mod 2^XLEN):
  - BRANCH: pc4 + (sext(imm) << 2), modulo 2^XLEN.
  - J/JAL: {pc4[XLEN-1:28], instr[25:0], 2'b00}.
  - All others, including JR: 0.
- Destination and write enable:
  - R-ALU → rd, write 1.
  - I-ALU/LOAD → rt, write 1.
  - JAL → 31, write 1.
  - All others → dest 0, write 0.
  - Any dest of 0 forces out_reg_write = 0.
- Field outputs (opcode, funct, rs, rt, shamt) are raw instruction slices in every class, including ILLEGAL.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - Payload holds stable while out_valid && !out_ready.

## Timing
- Latency: 1 cycle. An input accepted at edge N is visible from edge N (registered) with out_valid = 1.
- Throughput: 1 instruction/cycle while out_ready = 1.
- Reset (async assert, synchronous-to-clk deassert handled upstream): out_valid = 0 and every payload output = 0. Because out_valid = 0, in_ready reads 1 during reset.
- Reset mid-operation: the held instruction is lost and out_valid drops immediately, without waiting for a clock edge.
- Flush at edge N: out_valid = 0 after N. Any input presented that cycle is dropped even if in_ready = 1. Flush has priority over load and hold.
- Simultaneous out-transfer and in-transfer: the new instruction replaces the old one at the same edge, with no bubble.
- Payload registers update only on an in-transfer; on idle cycles they keep their last values.

## Test plan
- Reset: hold rst_n = 0 with in_valid = 1 → out_valid = 0, all outputs 0, in_ready = 1. Release, then send 0x2009FFFF (ADDI) → next cycle out_class = 1, out_imm = 0xFFFFFFFF, out_dest = 9, out_reg_write = 1.
- Immediate extension:
  - 0x3409FFFF (ORI) → out_imm = 0x0000FFFF.
  - 0x3C011234 (LUI) → out_imm = 0x12340000.
  - XLEN = 64, LUI 0x3C018000 → out_imm = 0xFFFFFFFF80000000.
- Targets:
  - BEQ 0x1000FFFF at pc 0x100 → out_class = 4, out_target = 0x100.
  - JAL 0x0C000010 at pc 0x40000000 → out_target = 0x40000040, out_dest = 31.
  - J at pc 0xFFFFFFFC → pc4 wraps to 0; out_target upper bits = 0.
- Illegal encodings: opcode 0x3F, and R-type funct 0x01 → out_class = 7, out_illegal = 1, out_reg_write = 0, out_imm = 0. R-type 0x00000020 (rd = 0) → out_reg_write = 0.
- Backpressure: stream 4 instructions while out_ready toggles 1,0,0,1,1… → no loss or duplication, payload stable during stall, in_ready = 0 only while out_valid && !out_ready.
- Flush: assert flush with out_valid = 1, out_ready = 0 and in_valid = 1 → out_valid = 0 next cycle, the input is dropped, and the next accepted instruction decodes normally.
